// File: rtl/mandel_dispatch_if.sv
// ============================================================================
// Module   : mandel_dispatch_if
// Purpose  : Bundles the frame parameters, processor handshake and dispatch outputs.
// Optional : MANDEL_DISPATCH_STATS_EN adds the oStallCycles statistics output.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mandel_dispatch_if #(
    parameter int NUM_PROC = 4,
    parameter int COORD_W  = 36
);
    logic                iStart;
    logic [COORD_W-1:0]  iXStart;
    logic [COORD_W-1:0]  iYStart;
    logic [COORD_W-1:0]  iStep;
    logic [NUM_PROC-1:0] iProcReady;
    logic [NUM_PROC-1:0] oDataVal;
    logic [COORD_W-1:0]  oCoordX;
    logic [COORD_W-1:0]  oCoordY;
    logic [9:0]          oVGAX;
    logic [8:0]          oVGAY;
    logic                oBusy;
    logic                oDone;
`ifdef MANDEL_DISPATCH_STATS_EN
    logic [23:0]         oStallCycles;
`endif

    modport master (
`ifdef MANDEL_DISPATCH_STATS_EN
        output oStallCycles,
`endif
        input  iStart, iXStart, iYStart, iStep, iProcReady,
        output oDataVal, oCoordX, oCoordY, oVGAX, oVGAY, oBusy, oDone
    );

    modport slave (
`ifdef MANDEL_DISPATCH_STATS_EN
        input  oStallCycles,
`endif
        output iStart, iXStart, iYStart, iStep, iProcReady,
        input  oDataVal, oCoordX, oCoordY, oVGAX, oVGAY, oBusy, oDone
    );
endinterface

`default_nettype wire

// File: rtl/mandel_dispatch.sv
// ============================================================================
// Module   : mandel_dispatch
// Purpose  : Raster scheduler handing fixed-point pixel coordinates to a bank of
//            Mandelbrot processors with round-robin arbitration and ready holdoff.
// Optional : MANDEL_DISPATCH_STATS_EN enables the 24-bit stall-cycle counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mandel_dispatch #(
    parameter int NUM_PROC = 4,
    parameter int H_RES    = 640,
    parameter int V_RES    = 480,
    parameter int COORD_W  = 36
) (
    input  wire logic          clk,
    input  wire logic          reset,
    mandel_dispatch_if.master  bus
);
    localparam int PTR_W = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]          r_state;
    logic [COORD_W-1:0]  r_xstart;
    logic [COORD_W-1:0]  r_step;
    logic [COORD_W-1:0]  r_curx;
    logic [COORD_W-1:0]  r_cury;
    logic [9:0]          r_px;
    logic [8:0]          r_py;
    logic [PTR_W-1:0]    r_rr;
    logic [NUM_PROC-1:0] r_dataval;
    logic [COORD_W-1:0]  r_coordx;
    logic [COORD_W-1:0]  r_coordy;
    logic [9:0]          r_vgax;
    logic [8:0]          r_vgay;
    logic                r_busy;
    logic                r_done;

    logic [NUM_PROC-1:0] w_mask;
    logic [NUM_PROC-1:0] w_elig;
    logic [NUM_PROC-1:0] w_grant_oh;
    logic [PTR_W:0]      w_idx;
    logic [PTR_W-1:0]    w_grant;
    logic [PTR_W-1:0]    w_rr_next;
    logic                w_found;
    logic                w_dispatch;
    logic                w_last;

    assign w_elig = bus.iProcReady & ~w_mask;

    // First eligible processor at or after the round-robin pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_PROC; k++) begin
            w_idx = {1'b0, r_rr} + (PTR_W+1)'(k);
            if (w_idx >= (PTR_W+1)'(NUM_PROC)) begin
                w_idx = w_idx - (PTR_W+1)'(NUM_PROC);
            end
            if (!w_found && w_elig[w_idx[PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_grant = w_idx[PTR_W-1:0];
            end
        end
    end

    assign w_dispatch = (r_state == S_SCAN) && w_found;
    assign w_grant_oh = w_dispatch ? (NUM_PROC'(1) << w_grant) : '0;
    assign w_rr_next  = (w_grant == PTR_W'(NUM_PROC-1)) ? '0 : w_grant + 1'b1;
    assign w_last     = (r_px == 10'(H_RES-1)) && (r_py == 9'(V_RES-1));

    // A processor's ready lags its grant by a cycle, so mask it for two cycles.
    for (genvar gi = 0; gi < NUM_PROC; gi++) begin : g_hold
        logic [1:0] r_cnt;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_cnt <= '0;
            end else if (w_grant_oh[gi]) begin
                r_cnt <= 2'd2;
            end else if (r_cnt != 2'd0) begin
                r_cnt <= r_cnt - 2'd1;
            end
        end
        assign w_mask[gi] = (r_cnt != 2'd0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_xstart  <= '0;
            r_step    <= '0;
            r_curx    <= '0;
            r_cury    <= '0;
            r_px      <= '0;
            r_py      <= '0;
            r_rr      <= '0;
            r_dataval <= '0;
            r_coordx  <= '0;
            r_coordy  <= '0;
            r_vgax    <= '0;
            r_vgay    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_dataval <= w_grant_oh;
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.iStart) begin
                        r_xstart <= bus.iXStart;
                        r_step   <= bus.iStep;
                        r_curx   <= bus.iXStart;
                        r_cury   <= bus.iYStart;
                        r_px     <= '0;
                        r_py     <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_found) begin
                        r_coordx <= r_curx;
                        r_coordy <= r_cury;
                        r_vgax   <= r_px;
                        r_vgay   <= r_py;
                        r_rr     <= w_rr_next;
                        if (w_last) begin
                            r_state <= S_DONE;
                        end else if (r_px != 10'(H_RES-1)) begin
                            r_px   <= r_px + 10'd1;
                            r_curx <= r_curx + r_step;
                        end else begin
                            r_px   <= '0;
                            r_curx <= r_xstart;
                            r_py   <= r_py + 9'd1;
                            r_cury <= r_cury - r_step;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef MANDEL_DISPATCH_STATS_EN
    logic [23:0] r_stall;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall <= '0;
        end else if (r_state == S_IDLE && bus.iStart) begin
            r_stall <= '0;
        end else if (r_state == S_SCAN && !w_found && r_stall != 24'hFF_FFFF) begin
            r_stall <= r_stall + 24'd1;
        end
    end
    assign bus.oStallCycles = r_stall;
`endif

    assign bus.oDataVal = r_dataval;
    assign bus.oCoordX  = r_coordx;
    assign bus.oCoordY  = r_coordy;
    assign bus.oVGAX    = r_vgax;
    assign bus.oVGAY    = r_vgay;
    assign bus.oBusy    = r_busy;
    assign bus.oDone    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_mandel_dispatch.sv
// ============================================================================
// Module   : tb_mandel_dispatch
// Purpose  : Scoreboard bench for mandel_dispatch on a reduced 8x3 raster.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mandel_dispatch;
    localparam int NP = 4;
    localparam int H  = 8;
    localparam int V  = 3;
    localparam int CW = 36;

    typedef struct {
        logic [NP-1:0] oh;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [9:0]    vx;
        logic [8:0]    vy;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   n_strobes = 0;
    int   n_done = 0;
    int   last_cyc = 0;
    bit   have_last = 1'b0;
    int   exp_gap = 0;
    exp_t q[$];
    logic [CW-1:0] log_x[$];
    logic [CW-1:0] log_y[$];
    logic [9:0]    log_vx[$];
    logic [8:0]    log_vy[$];

    mandel_dispatch_if #(.NUM_PROC(NP), .COORD_W(CW)) bus ();

    mandel_dispatch #(.NUM_PROC(NP), .H_RES(H), .V_RES(V), .COORD_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_frame(input logic [CW-1:0] xs, input logic [CW-1:0] ys,
                              input logic [CW-1:0] st, input bit single, input int rr0);
        exp_t e;
        int   n;
        for (int py = 0; py < V; py++) begin
            for (int px = 0; px < H; px++) begin
                n    = py * H + px;
                e.oh = single ? 4'b0100 : 4'(1 << ((rr0 + n) % NP));
                e.x  = xs + 36'(px) * st;
                e.y  = ys - 36'(py) * st;
                e.vx = 10'(px);
                e.vy = 9'(py);
                q.push_back(e);
            end
        end
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (bus.oDataVal != '0) begin
            n_strobes++;
            log_x.push_back(bus.oCoordX);
            log_y.push_back(bus.oCoordY);
            log_vx.push_back(bus.oVGAX);
            log_vy.push_back(bus.oVGAY);
            if (q.size() == 0) begin
                chk("unexpected_strobe", {60'd0, bus.oDataVal}, 64'd0);
            end else begin
                e = q.pop_front();
                chk("strobe_proc", bus.oDataVal, e.oh);
                chk("coord_x", bus.oCoordX, e.x);
                chk("coord_y", bus.oCoordY, e.y);
                chk("vga_x", bus.oVGAX, e.vx);
                chk("vga_y", bus.oVGAY, e.vy);
            end
            chk("busy_in_frame", bus.oBusy, 1'b1);
            if (have_last && exp_gap != 0) chk("strobe_gap", cyc - last_cyc, exp_gap);
            last_cyc  = cyc;
            have_last = 1'b1;
        end
        if (bus.oDone) begin
            n_done++;
            chk("done_latency", cyc - last_cyc, 1);
            chk("busy_at_done", bus.oBusy, 1'b0);
            chk("queue_empty_at_done", q.size(), 0);
        end
    end

    task automatic start_frame(input logic [CW-1:0] xs, input logic [CW-1:0] ys,
                               input logic [CW-1:0] st);
        @(negedge clk);
        bus.iXStart = xs;
        bus.iYStart = ys;
        bus.iStep   = st;
        bus.iStart  = 1'b1;
        @(negedge clk);
        bus.iStart  = 1'b0;
    endtask

    task automatic wait_strobes(input int n);
        int t;
        for (t = 0; t < 2000; t++) begin
            @(negedge clk);
            #1;
            if (n_strobes >= n) break;
        end
        if (t == 2000) chk("wait_strobes_timeout", n_strobes, n);
    endtask

    task automatic wait_done(input int d0);
        int t;
        for (t = 0; t < 2000; t++) begin
            @(negedge clk);
            #1;
            if (n_done > d0) break;
        end
        if (t == 2000) chk("wait_done_timeout", n_done, d0 + 1);
        repeat (3) @(negedge clk);
        chk("single_done_pulse", n_done, d0 + 1);
    endtask

    task automatic new_frame_state();
        n_strobes = 0;
        have_last = 1'b0;
        log_x.delete();
        log_y.delete();
        log_vx.delete();
        log_vy.delete();
    endtask

    initial begin
        int c0;
        int d0;
        bus.iStart     = 1'b0;
        bus.iXStart    = '0;
        bus.iYStart    = '0;
        bus.iStep      = '0;
        bus.iProcReady = '0;

        repeat (3) @(negedge clk);
        chk("rst_dataval", bus.oDataVal, 0);
        chk("rst_coordx", bus.oCoordX, 0);
        chk("rst_coordy", bus.oCoordY, 0);
        chk("rst_vgax", bus.oVGAX, 0);
        chk("rst_vgay", bus.oVGAY, 0);
        chk("rst_busy", bus.oBusy, 0);
        chk("rst_done", bus.oDone, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Frame A: all ready, one pixel per cycle, 50-cycle stall mid-row.
        new_frame_state();
        bus.iProcReady = 4'hF;
        exp_gap = 1;
        d0 = n_done;
        push_frame(36'hE_0000_0000, 36'h1_0000_0000, 36'h0_0100_0000, 1'b0, 0);
        start_frame(36'hE_0000_0000, 36'h1_0000_0000, 36'h0_0100_0000);
        wait_strobes(3);
        bus.iProcReady = 4'h0;
        c0 = n_strobes;
        repeat (50) @(negedge clk);
        #1;
        chk("stall_no_strobe", n_strobes, c0);
        chk("stall_busy", bus.oBusy, 1'b1);
        exp_gap = 51;
        bus.iProcReady = 4'hF;
        wait_strobes(c0 + 1);
        exp_gap = 1;
        wait_done(d0);
        chk("A_strobe_count", n_strobes, H * V);
        chk("A_px1_x", log_x[1], 36'hE_0100_0000);
        chk("A_row1_x", log_x[8], 36'hE_0000_0000);
        chk("A_row1_y", log_y[8], 36'h0_FF00_0000);
        chk("A_last_vx", log_vx[H*V-1], 10'd7);
        chk("A_last_vy", log_vy[H*V-1], 9'd2);
`ifdef MANDEL_DISPATCH_STATS_EN
        chk("A_stall_cycles", bus.oStallCycles, 24'd50);
`endif

        // Frame B: only processor 2 ready, wrapping coordinates, ignored mid-frame start.
        new_frame_state();
        bus.iProcReady = 4'b0100;
        exp_gap = 3;
        d0 = n_done;
        push_frame(36'h7_FF00_0000, 36'h8_0000_0000, 36'h0_0080_0000, 1'b1, 0);
        start_frame(36'h7_FF00_0000, 36'h8_0000_0000, 36'h0_0080_0000);
        wait_strobes(5);
        bus.iXStart = '0;
        bus.iStep   = 36'h0_1234_0000;
        bus.iStart  = 1'b1;
        @(negedge clk);
        bus.iStart  = 1'b0;
        wait_done(d0);
        chk("B_strobe_count", n_strobes, H * V);
        chk("B_wrap_x", log_x[7], 36'h8_0280_0000);
        chk("B_wrap_y", log_y[8], 36'h7_FF80_0000);

        // Frame C: abandoned by a one-cycle reset after five pixels.
        new_frame_state();
        bus.iProcReady = 4'hF;
        exp_gap = 1;
        push_frame(36'h0_1000_0000, 36'h0_2000_0000, 36'h0_0001_0000, 1'b0, 3);
        start_frame(36'h0_1000_0000, 36'h0_2000_0000, 36'h0_0001_0000);
        wait_strobes(5);
        reset = 1'b0;
        #1;
        chk("mid_rst_dataval", bus.oDataVal, 0);
        chk("mid_rst_coordx", bus.oCoordX, 0);
        chk("mid_rst_vgax", bus.oVGAX, 0);
        chk("mid_rst_busy", bus.oBusy, 0);
        q.delete();
        @(negedge clk);
        reset = 1'b1;
        c0 = n_strobes;
        repeat (4) @(negedge clk);
        #1;
        chk("idle_after_rst", n_strobes, c0);

        // Frame D: restarts at pixel (0,0) with the pointer back at processor 0.
        new_frame_state();
        d0 = n_done;
        push_frame(36'h0_1000_0000, 36'h0_2000_0000, 36'h0_0001_0000, 1'b0, 0);
        start_frame(36'h0_1000_0000, 36'h0_2000_0000, 36'h0_0001_0000);
        wait_done(d0);
        chk("D_strobe_count", n_strobes, H * V);
        chk("D_first_x", log_x[0], 36'h0_1000_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
